// File: rtl/moore_seq_det_pkg.sv
// Shared constants for the serial pattern detector: default pattern, legal
// pattern-length range and the width of the history fill counter.
package moore_seq_det_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    localparam logic [3:0] DEFAULT_PAT = 4'b1101;

    // Enough bits to hold 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/moore_seq_detector_match_counter.sv
// Saturating match counter: advances by one per cycle with inc high and sticks at all-ones.
// Latency one clock; no backpressure.
module match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: o rises the cycle after the last pattern bit is shifted in;
// no backpressure. MOORE_SEQ_DET_COUNT_EN adds the saturating match counter.
module moore_seq_detector
    import moore_seq_det_pkg::*;
#(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(DEFAULT_PAT),
    parameter int               CNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           shift_enable,
    input  logic                           i,
    input  logic                           overlap,
    input  logic                           load_pat,
    input  logic [PAT_W-1:0]               pat_in,
    output logic                           o,
    output logic [fill_width(PAT_W)-1:0]   fill,
    output logic [CNT_W-1:0]               match_count
);

    localparam int FW = fill_width(PAT_W);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("moore_seq_detector: PAT_W out of range");
    end

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [FW-1:0]    fill_nxt;
    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-1:0] pat_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist    <= '0;
            fill    <= '0;
            pat_reg <= RESET_PAT;
        end else begin
            hist    <= hist_nxt;
            fill    <= fill_nxt;
            pat_reg <= pat_nxt;
        end
    end

    // A load wins over a concurrent shift; the sampled bit is dropped.
    always_comb begin
        hist_nxt = hist;
        fill_nxt = fill;
        pat_nxt  = pat_reg;
        if (load_pat) begin
            pat_nxt  = pat_in;
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (shift_enable) begin
            hist_nxt = {hist[PAT_W-2:0], i};
            if (o && !overlap) begin
                fill_nxt = FW'(1);
            end else if (fill != FW'(PAT_W)) begin
                fill_nxt = fill + FW'(1);
            end
        end
    end

    always_comb begin
        o = (fill == FW'(PAT_W)) && (hist == pat_reg);
    end

`ifdef MOORE_SEQ_DET_COUNT_EN
    logic match_nxt;
    logic count_inc;

    // Only an accepted shift can create a match; a load always clears it.
    always_comb begin
        match_nxt = (fill_nxt == FW'(PAT_W)) && (hist_nxt == pat_nxt);
        count_inc = shift_enable && !load_pat && match_nxt;
    end

    match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (count_inc),
        .count (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector with a queue-based reference model checked every cycle.
module tb_moore_seq_detector;

    localparam int PAT_W = 4;

`ifdef MOORE_SEQ_DET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic       shift_enable;
    logic       i;
    logic       overlap;
    logic       load_pat;
    logic [3:0] pat_in;

    logic       o_a, o_b;
    logic [2:0] fill_a, fill_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    moore_seq_detector #(.PAT_W(PAT_W), .RESET_PAT(4'b1101), .CNT_W(8)) dut_a (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .i(i),
        .overlap(overlap), .load_pat(load_pat), .pat_in(pat_in),
        .o(o_a), .fill(fill_a), .match_count(cnt_a)
    );

    moore_seq_detector #(.PAT_W(PAT_W), .RESET_PAT(4'b1101), .CNT_W(2)) dut_b (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .i(i),
        .overlap(overlap), .load_pat(load_pat), .pat_in(pat_in),
        .o(o_b), .fill(fill_b), .match_count(cnt_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: bits received since the last clear, oldest first.
    bit         mq[$];
    logic [3:0] m_pat;
    int         m_cnt;

    function automatic bit m_match();
        if (mq.size() != PAT_W) return 1'b0;
        for (int k = 0; k < PAT_W; k++) begin
            if (mq[k] != m_pat[PAT_W-1-k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mq.delete();
            m_pat = 4'b1101;
            m_cnt = 0;
        end else if (load_pat) begin
            m_pat = pat_in;
            mq.delete();
        end else if (shift_enable) begin
            if (m_match() && !overlap) mq.delete();
            mq.push_back(i);
            if (mq.size() > PAT_W) void'(mq.pop_front());
            if (m_match()) m_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_o_a",    32'(o_a),    32'(m_match()));
        chk("model_o_b",    32'(o_b),    32'(m_match()));
        chk("model_fill_a", 32'(fill_a), 32'(mq.size()));
        chk("model_fill_b", 32'(fill_b), 32'(mq.size()));
        chk("model_cnt_a",  32'(cnt_a),  CNT_ON ? 32'((m_cnt > 255) ? 255 : m_cnt) : 32'd0);
        chk("model_cnt_b",  32'(cnt_b),  CNT_ON ? 32'((m_cnt > 3) ? 3 : m_cnt) : 32'd0);
    end

    task automatic send(input logic b, input logic exp_o);
        @(negedge clk);
        i            = b;
        shift_enable = 1'b1;
        load_pat     = 1'b0;
        @(posedge clk);
        #1;
        chk("lit_o", 32'(o_a), 32'(exp_o));
    endtask

    task automatic send_seq(input logic [15:0] bits, input logic [15:0] exp, input int n);
        for (int k = 0; k < n; k++) begin
            send(bits[n-1-k], exp[n-1-k]);
        end
    endtask

    task automatic idle(input int n, input logic exp_o, input int exp_fill);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            shift_enable = 1'b0;
            load_pat     = 1'b0;
            i            = ~i;
            @(posedge clk);
            #1;
            chk("hold_o",    32'(o_a),    32'(exp_o));
            chk("hold_fill", 32'(fill_a), 32'(exp_fill));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        shift_enable = 1'b0;
        load_pat     = 1'b0;
        #2 n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_rst        = 1'b1;
        shift_enable = 1'b0;
        i            = 1'b0;
        overlap      = 1'b1;
        load_pat     = 1'b0;
        pat_in       = 4'b0000;

        // Power-on reset asserted mid-period, held across an edge, then released.
        #2 n_rst = 1'b0;
        #1;
        chk("rst_o",    32'(o_a),    32'd0);
        chk("rst_fill", 32'(fill_a), 32'd0);
        chk("rst_cnt",  32'(cnt_a),  32'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_o",    32'(o_a),    32'd0);
        chk("rst_edge_fill", 32'(fill_a), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_fill", 32'(fill_a), 32'd0);
        chk("rel_cnt",  32'(cnt_a),  32'd0);

        // No match anywhere in the stream.
        send_seq(16'b110010100111, 16'b0, 12);
        chk("nomatch_cnt", 32'(cnt_a), 32'd0);

        // Single match on the reset pattern.
        do_reset();
        send_seq(16'b11010, 16'b00010, 5);
        chk("single_cnt", 32'(cnt_a), CNT_ON ? 32'd1 : 32'd0);

        // Overlapping matches.
        do_reset();
        overlap = 1'b1;
        send_seq(16'b11011011, 16'b00010010, 8);
        chk("ovl_cnt", 32'(cnt_a), CNT_ON ? 32'd2 : 32'd0);

        // Non-overlapping: history restarts after the first match.
        do_reset();
        overlap = 1'b0;
        send_seq(16'b11011011, 16'b00010000, 8);
        chk("novl_cnt", 32'(cnt_a), CNT_ON ? 32'd1 : 32'd0);
        overlap = 1'b1;

        // Reload with a concurrent shift: load wins, bit dropped.
        do_reset();
        @(negedge clk);
        load_pat     = 1'b1;
        pat_in       = 4'b0110;
        shift_enable = 1'b1;
        i            = 1'b1;
        @(posedge clk);
        #1;
        chk("load_fill", 32'(fill_a), 32'd0);
        chk("load_o",    32'(o_a),    32'd0);
        send_seq(16'b0110, 16'b0001, 4);
        chk("load_match_fill", 32'(fill_a), 32'd4);

        // Enable low mid-pattern, then hold o high with enable low.
        do_reset();
        send_seq(16'b11, 16'b00, 2);
        idle(3, 1'b0, 2);
        send_seq(16'b01, 16'b01, 2);
        idle(2, 1'b1, 4);

        // Reset after the third bit of 1101: the fourth bit must not match.
        do_reset();
        send_seq(16'b110, 16'b000, 3);
        @(negedge clk);
        shift_enable = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_fill", 32'(fill_a), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        send(1'b1, 1'b0);
        chk("midrst_after_fill", 32'(fill_a), 32'd1);

        // Five overlapping matches saturate the 2-bit counter.
        do_reset();
        overlap = 1'b1;
        send_seq(16'b1101101101101101, 16'b0001001001001001, 16);
        chk("sat_cnt_a", 32'(cnt_a), CNT_ON ? 32'd5 : 32'd0);
        chk("sat_cnt_b", 32'(cnt_b), CNT_ON ? 32'd3 : 32'd0);

        @(negedge clk);
        shift_enable = 1'b0;
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
